dmem_arb3: RTL and testbench

//  Three-initiator to one-target arbiter for the dmem bus: the many-to-one counterpart of the address-decode mux.

---
 rtl/dmem_arb3_if.sv | 23 ++
 rtl/dmem_arb3.sv | 152 +++++++++++++++
 tb/tb_dmem_arb3.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb3_if.sv
// dmem bus port: one initiator-to-target request/response channel.
// Latency: none, wires only.
// Backpressure: target stalls a request by holding accept low; responses return in order via ack.
interface dmem_arb3_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wr;
    logic        rd;
    logic        burst;
    logic        accept;
    logic        ack;

    modport master (
        output addr, wdata, wr, rd, burst,
        input  rdata, accept, ack
    );

    modport slave (
        input  addr, wdata, wr, rd, burst,
        output rdata, accept, ack
    );
endinterface

// File: rtl/dmem_arb3.sv
// Round-robin arbiter sharing one dmem target between three initiators.
// Latency: 1 cycle from IDLE to first forward, then same-cycle pass-through while granted.
// Backpressure: target accept passes to the owner; forwarding stops at MAX_OUTSTANDING unacked.
module dmem_arb3 #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dmem_arb3_if.slave  in0,
    dmem_arb3_if.slave  in1,
    dmem_arb3_if.slave  in2,
    dmem_arb3_if.master out
);
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    state_t      state;
    logic [1:0]  owner;
    logic [1:0]  last;
    logic [2:0]  cnt;
    logic        lock;

    logic [2:0]  req;
    logic [2:0]  own_oh;
    logic [1:0]  win;
    logic [1:0]  ord_a;
    logic [1:0]  ord_b;
    logic [1:0]  ord_c;
    logic [31:0] own_addr;
    logic [31:0] own_wdata;
    logic [3:0]  own_wr;
    logic        own_rd;
    logic        own_burst;
    logic        own_req;
    logic        others_req;
    logic        busy;
    logic        fwd;
    logic        acc;
    logic        dec;
    logic [2:0]  cnt_next;

    assign req = {(|in2.wr) | in2.rd, (|in1.wr) | in1.rd, (|in0.wr) | in0.rd};

    // Search order starts just after the previous winner so every requester gets a turn.
    always_comb begin
        ord_a = 2'd0;
        ord_b = 2'd1;
        ord_c = 2'd2;
        case (last)
            2'd0:    begin ord_a = 2'd1; ord_b = 2'd2; ord_c = 2'd0; end
            2'd1:    begin ord_a = 2'd2; ord_b = 2'd0; ord_c = 2'd1; end
            default: ;
        endcase
        win = ord_c;
        if (req[ord_a])
            win = ord_a;
        else if (req[ord_b])
            win = ord_b;
    end

    always_comb begin
        own_addr  = '0;
        own_wdata = '0;
        own_wr    = '0;
        own_rd    = 1'b0;
        own_burst = 1'b0;
        case (owner)
            2'd0: begin
                own_addr = in0.addr; own_wdata = in0.wdata; own_wr = in0.wr;
                own_rd   = in0.rd;   own_burst = in0.burst;
            end
            2'd1: begin
                own_addr = in1.addr; own_wdata = in1.wdata; own_wr = in1.wr;
                own_rd   = in1.rd;   own_burst = in1.burst;
            end
            2'd2: begin
                own_addr = in2.addr; own_wdata = in2.wdata; own_wr = in2.wr;
                own_rd   = in2.rd;   own_burst = in2.burst;
            end
            default: ;
        endcase
    end

    assign own_oh     = 3'b001 << owner;
    assign own_req    = (|own_wr) | own_rd;
    assign others_req = |(req & ~own_oh);
    assign busy       = (state != IDLE);
    assign fwd        = (state == GRANT) && (cnt < MAX_CNT);
    assign acc        = fwd && own_req && out.accept;
    // Acks with nothing outstanding are stale (e.g. from before a reset) and are dropped.
    assign dec        = out.ack && busy && (cnt != 3'd0);

    always_comb begin
        cnt_next = cnt;
        if (acc && !dec)
            cnt_next = cnt + 3'd1;
        else if (dec && !acc)
            cnt_next = cnt - 3'd1;
    end

    assign out.addr  = fwd ? own_addr  : '0;
    assign out.wdata = fwd ? own_wdata : '0;
    assign out.wr    = fwd ? own_wr    : '0;
    assign out.rd    = fwd & own_rd;
    assign out.burst = fwd & own_burst;

    assign in0.accept = acc & own_oh[0];
    assign in1.accept = acc & own_oh[1];
    assign in2.accept = acc & own_oh[2];
    assign in0.ack    = dec & own_oh[0];
    assign in1.ack    = dec & own_oh[1];
    assign in2.ack    = dec & own_oh[2];
    assign in0.rdata  = (busy && own_oh[0]) ? out.rdata : '0;
    assign in1.rdata  = (busy && own_oh[1]) ? out.rdata : '0;
    assign in2.rdata  = (busy && own_oh[2]) ? out.rdata : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            owner <= 2'd0;
            last  <= 2'd2;
            cnt   <= 3'd0;
            lock  <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (acc)
                lock <= own_burst;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner <= win;
                        last  <= win;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // Closing a non-burst access while others wait hands the bus on once acks drain.
                    if (acc && !own_burst && others_req)
                        state <= DRAIN;
                    else if (cnt_next == 3'd0 && !lock && !own_req)
                        state <= IDLE;
                end
                DRAIN: begin
                    if (cnt_next == 3'd0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arb3.sv
// Bench for dmem_arb3: directed scenarios plus randomized traffic against a transaction-level model
// (per-initiator beat queues, in-order response queue, burst ownership and outstanding-limit rules).
module tb_dmem_arb3;
    localparam int MAX = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wr;
        logic        rd;
        logic        burst;
    } beat_t;

    typedef struct {
        int          id;
        logic        rd;
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_i;

    always #5 clk = ~clk;

    dmem_arb3_if i0();
    dmem_arb3_if i1();
    dmem_arb3_if i2();
    dmem_arb3_if o();

    dmem_arb3 #(.MAX_OUTSTANDING(MAX)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .in0   (i0),
        .in1   (i1),
        .in2   (i2),
        .out   (o)
    );

    int    total = 0;
    int    bad   = 0;
    beat_t iq[3][$];
    rsp_t  rq[$];
    bit    active[3];
    int    lock_id;
    int    acc_log[$];
    int    stamps[$];
    int    peak;
    int    last_due;
    bit    done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                                 input logic r, input logic b);
        beat_t x;
        x.addr = a; x.wdata = d; x.wr = w; x.rd = r; x.burst = b;
        return x;
    endfunction

    task automatic drive_in(input int i, input beat_t b);
        case (i)
            0: begin i0.addr = b.addr; i0.wdata = b.wdata; i0.wr = b.wr; i0.rd = b.rd; i0.burst = b.burst; end
            1: begin i1.addr = b.addr; i1.wdata = b.wdata; i1.wr = b.wr; i1.rd = b.rd; i1.burst = b.burst; end
            default: begin i2.addr = b.addr; i2.wdata = b.wdata; i2.wr = b.wr; i2.rd = b.rd; i2.burst = b.burst; end
        endcase
    endtask

    function automatic logic get_acc(input int i);
        case (i)
            0: return i0.accept;
            1: return i1.accept;
            default: return i2.accept;
        endcase
    endfunction

    function automatic logic get_ack(input int i);
        case (i)
            0: return i0.ack;
            1: return i1.ack;
            default: return i2.ack;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int i);
        case (i)
            0: return i0.rdata;
            1: return i1.rdata;
            default: return i2.rdata;
        endcase
    endfunction

    function automatic logic any_out();
        return |{o.addr, o.wdata, o.wr, o.rd, o.burst,
                 i0.accept, i0.ack, i0.rdata, i1.accept, i1.ack, i1.rdata,
                 i2.accept, i2.ack, i2.rdata};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        for (int i = 0; i < 3; i++) drive_in(i, mk(0, 0, 0, 0, 0));
        o.accept = 1'b0;
        o.ack    = 1'b0;
        o.rdata  = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        quiet();
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    // One bus cycle per iteration: drive at negedge, check settled outputs, then advance the model.
    task automatic run(input int acc_pct, input int dmin, input int dmax, input int gap_pct,
                       input int stray_pct, input int budget);
        int    n_acc, n_ack, k;
        bit    ackv, stray, out_req;
        beat_t hb;
        rsp_t  r;
        rq.delete(); acc_log.delete(); stamps.delete();
        lock_id = -1; peak = 0; last_due = 0; done = 0;
        for (int i = 0; i < 3; i++) active[i] = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (iq[0].size() == 0 && iq[1].size() == 0 && iq[2].size() == 0 && rq.size() == 0) begin
                done = 1;
                break;
            end
            for (int i = 0; i < 3; i++) begin
                if (!active[i] && iq[i].size() > 0 && $urandom_range(0, 99) >= gap_pct)
                    active[i] = 1;
                drive_in(i, active[i] ? iq[i][0] : mk(0, 0, 0, 0, 0));
            end
            o.accept = ($urandom_range(0, 99) < acc_pct);
            ackv  = (rq.size() > 0) && (rq[0].due <= cyc);
            stray = (rq.size() == 0) && ($urandom_range(0, 99) < stray_pct);
            o.ack   = ackv | stray;
            o.rdata = ackv ? rq[0].data : $urandom;
            #1;
            out_req = o.rd | (|o.wr);
            n_acc = 0; n_ack = 0; k = -1;
            for (int i = 0; i < 3; i++) begin
                if (get_acc(i)) begin n_acc++; k = i; end
                if (get_ack(i)) n_ack++;
            end
            chk("acc_count", 32'(n_acc), 32'(out_req && o.accept));
            if (out_req) chk("cap", 32'(rq.size() < MAX), 32'd1);
            chk("ack_count", 32'(n_ack), 32'(ackv));
            if (ackv) begin
                chk("ack_route", 32'(get_ack(rq[0].id)), 32'd1);
                if (rq[0].rd) chk("rdata", get_rdata(rq[0].id), rq[0].data);
                void'(rq.pop_front());
            end
            if (n_acc == 1) begin
                chk("acc_req", 32'(active[k]), 32'd1);
                if (lock_id >= 0) chk("burst_contig", 32'(k), 32'(lock_id));
                hb = iq[k][0];
                chk("fwd_addr", o.addr, hb.addr);
                chk("fwd_wdata", o.wdata, hb.wdata);
                chk("fwd_ctl", 32'({o.wr, o.rd, o.burst}), 32'({hb.wr, hb.rd, hb.burst}));
                r.id = k; r.rd = hb.rd; r.data = $urandom;
                r.due = cyc + $urandom_range(dmin, dmax);
                if (r.due < last_due) r.due = last_due;
                last_due = r.due;
                rq.push_back(r);
                acc_log.push_back(k);
                stamps.push_back(cyc);
                lock_id = hb.burst ? k : -1;
                void'(iq[k].pop_front());
                if (!hb.burst) active[k] = 0;
            end
            if (rq.size() > peak) peak = rq.size();
            tick();
        end
        quiet();
        chk("drain_done", 32'(done), 32'd1);
    endtask

    task automatic chk_log(input string tag, input int exp[$]);
        chk({tag, "_len"}, 32'(acc_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < acc_log.size(); i++)
            chk(tag, 32'(acc_log[i]), 32'(exp[i]));
    endtask

    initial begin
        int len;
        logic rdf;
        rst_i = 1'b0;
        quiet();
        tick();

        // Reset with live-looking inputs: every output must stay 0.
        drive_in(0, mk(32'h40, 32'h1, 4'h0, 1'b1, 1'b0));
        o.accept = 1'b1; o.ack = 1'b1; o.rdata = 32'hDEADBEEF;
        #1 chk("rst_outs", 32'(any_out()), 32'd0);
        quiet();
        tick();
        rst_i = 1'b1;

        // Single read from in1.
        drive_in(1, mk(32'h10, 32'h0, 4'h0, 1'b1, 1'b0));
        #1;
        chk("t1_idle_rd", 32'(o.rd), 32'd0);
        chk("t1_idle_acc", 32'(i1.accept), 32'd0);
        tick();
        #1;
        chk("t1_out_rd", 32'(o.rd), 32'd1);
        chk("t1_out_addr", o.addr, 32'h10);
        o.accept = 1'b1;
        #1;
        chk("t1_acc", 32'(i1.accept), 32'd1);
        chk("t1_acc_other", 32'({i0.accept, i2.accept}), 32'd0);
        tick();
        drive_in(1, mk(0, 0, 0, 0, 0));
        o.accept = 1'b0; o.ack = 1'b1; o.rdata = 32'hA5A5A5A5;
        #1;
        chk("t1_ack", 32'(i1.ack), 32'd1);
        chk("t1_data", i1.rdata, 32'hA5A5A5A5);
        chk("t1_data_other", i0.rdata, 32'd0);
        tick();
        o.ack = 1'b0;
        #1 chk("t1_idle_data", i1.rdata, 32'd0);
        quiet();

        // Simultaneous requests: round robin 0,1,2 twice.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) iq[i].push_back(mk(32'(i * 16 + r), 0, 4'h0, 1'b1, 1'b0));
            run(100, 1, 1, 0, 0, 200);
            chk_log("t2_order", '{0, 1, 2});
        end

        // in0 burst of four writes while in2 waits.
        do_reset();
        for (int b = 0; b < 4; b++) iq[0].push_back(mk(32'h200 + 32'(b * 4), $urandom, 4'hF, 1'b0, b < 3));
        iq[2].push_back(mk(32'h300, 0, 4'h0, 1'b1, 1'b0));
        run(100, 1, 1, 0, 0, 200);
        chk_log("t3_order", '{0, 0, 0, 0, 2});

        // Outstanding limit with slow acks.
        do_reset();
        for (int b = 0; b < 8; b++) iq[0].push_back(mk(32'h400 + 32'(b * 4), 0, 4'h0, 1'b1, 1'b0));
        run(100, 6, 6, 0, 0, 400);
        chk("t4_peak", 32'(peak), 32'(MAX));
        chk("t4_count", 32'(stamps.size()), 32'd8);
        if (stamps.size() >= 5) chk("t4_gap", 32'(stamps[4] - stamps[0]), 32'd7);

        // Accept+ack together at cnt=2, and ack at cnt=0.
        do_reset();
        drive_in(0, mk(32'h500, 0, 4'h0, 1'b1, 1'b0));
        tick();
        o.ack = 1'b1;
        #1 chk("t5_ack_cnt0", 32'(i0.ack), 32'd0);
        o.ack = 1'b0; o.accept = 1'b1;
        tick();
        tick();
        o.ack = 1'b1;
        #1;
        chk("t5_both_acc", 32'(i0.accept), 32'd1);
        chk("t5_both_ack", 32'(i0.ack), 32'd1);
        tick();
        drive_in(0, mk(0, 0, 0, 0, 0));
        o.accept = 1'b0;
        #1 chk("t5_ack_a", 32'(i0.ack), 32'd1);
        tick();
        #1 chk("t5_ack_b", 32'(i0.ack), 32'd1);
        tick();
        #1 chk("t5_ack_extra", 32'(i0.ack), 32'd0);
        tick();
        quiet();

        // Reset mid-operation with in1 owning and three outstanding.
        do_reset();
        drive_in(1, mk(32'h600, 0, 4'h0, 1'b1, 1'b0));
        tick();
        o.accept = 1'b1;
        tick(); tick(); tick();
        o.ack = 1'b1;
        rst_i = 1'b0;
        #1 chk("t6_rst_outs", 32'(any_out()), 32'd0);
        quiet();
        tick();
        rst_i = 1'b1;
        o.ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("t6_late_ack", 32'({i0.ack, i1.ack, i2.ack}), 32'd0);
            tick();
        end
        o.ack = 1'b0;
        for (int i = 0; i < 3; i++) drive_in(i, mk(32'h100 * 32'(i + 1), 0, 4'h0, 1'b1, 1'b0));
        tick();
        #1 chk("t6_first_owner", o.addr, 32'h100);
        quiet();

        // Randomized mixed traffic, two target profiles.
        for (int p = 0; p < 2; p++) begin
            do_reset();
            for (int i = 0; i < 3; i++) begin
                for (int t = 0; t < 12; t++) begin
                    len = $urandom_range(1, 4);
                    rdf = 1'($urandom_range(0, 1));
                    for (int b = 0; b < len; b++)
                        iq[i].push_back(mk($urandom, $urandom, rdf ? 4'h0 : 4'($urandom_range(1, 15)),
                                           rdf, b < len - 1));
                end
            end
            if (p == 0) run(60, 1, 5, 40, 5, 20000);
            else        run(90, 3, 8, 10, 5, 20000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
